serial_adder: RTL



---
 rtl/serial_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built on one full-adder cell
// Define SERIAL_ADDER_ASSERT_EN to compile in shadow-operand self-check assertions.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic             carry_d;
  logic             bit_s;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;

  assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign carry_d  = (a_sr_q[0] & b_sr_q[0]) | (b_sr_q[0] & carry_q) | (carry_q & a_sr_q[0]);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = bit_s;
    end else begin : g_res_wn
      assign res_d = {bit_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            sum     <= res_d;
            cout    <= carry_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_ASSERT_EN
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic             sh_cin_q;
  logic             done_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sh_cin_q    <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        sh_a_q   <= a;
        sh_b_q   <= b;
        sh_cin_q <= cin;
      end
      done_prev_q <= done;
      if (done) begin
        assert ({cout, sum} == ({1'b0, sh_a_q} + {1'b0, sh_b_q} + {{WIDTH{1'b0}}, sh_cin_q}))
        else $error("serial_adder: a=%0h b=%0h cin=%0b gave cout=%0b sum=%0h",
                    sh_a_q, sh_b_q, sh_cin_q, cout, sum);
      end
      assert (!(busy && done))
      else $error("serial_adder: busy and done high together");
      assert (!(done && done_prev_q))
      else $error("serial_adder: done high on consecutive cycles");
    end
  end
`else
  // Plain build: no shadow operands are kept.
`endif

endmodule
